param_paritysel_mux: RTL and testbench

Parameterised two-way data selector. The routing choice comes from the even/odd value of a multi-bit select code: even codes pass `data_a`, odd codes pass `data_b`. It is a datapath steering element between two equal-width sources and one consumer. It has an optional output register and reports side-band flags for the selected source and the parity of the selected word.

---
 rtl/paritysel_pkg.sv | 18 +
 rtl/param_paritysel_mux.sv | 101 ++++++++++
 tb/tb_param_paritysel_mux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/paritysel_pkg.sv
// -----------------------------------------------------------------------------
// paritysel_pkg
// Shared definitions for the parity-select mux and its users:
//   DEF_WIDTH  - default data width
//   DEF_SEL_W  - default select-code width
//   sel_src_e  - which source a word came from (SRC_A = even code, SRC_B = odd)
// -----------------------------------------------------------------------------
package paritysel_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 5;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } sel_src_e;

endpackage : paritysel_pkg

// File: rtl/param_paritysel_mux.sv
// -----------------------------------------------------------------------------
// param_paritysel_mux
// Two-way data selector steered by the even/odd value of a select code.
// Even codes pass data_a and odd codes pass data_b. Only sel[0] is used.
// Optional output register (REG_OUT=1) with asynchronous active-low reset.
//
// Parameters:
//   WIDTH   - data width of data_a, data_b, data_out (>= 1)
//   SEL_W   - width of sel (>= 1)
//   REG_OUT - 1: registered outputs, 1-cycle latency; 0: combinational
//
// Ports:
//   clk        in   clock (unused when REG_OUT=0)
//   rst_n      in   async active-low reset (unused when REG_OUT=0)
//   sel        in   [SEL_W-1:0] select code, only bit 0 matters
//   data_a     in   [WIDTH-1:0] source for even codes
//   data_b     in   [WIDTH-1:0] source for odd codes
//   data_out   out  [WIDTH-1:0] selected word
//   sel_odd    out  1 when data_out carries data_b
//   out_parity out  XOR reduction of data_out
// -----------------------------------------------------------------------------
module param_paritysel_mux
    import paritysel_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] data_out,
    output logic             sel_odd,
    output logic             out_parity
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("param_paritysel_mux: WIDTH must be >= 1");
        end
        if (SEL_W < 1) begin : g_bad_sel_w
            $error("param_paritysel_mux: SEL_W must be >= 1");
        end
    endgenerate

    function automatic logic word_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    // Upper select bits deliberately have no effect on routing.
    logic unused_sel_hi;
    assign unused_sel_hi = ^sel;

    // ---- Stage p0: select decode and parity of the next-state word ----
    sel_src_e         src_p0;
    logic [WIDTH-1:0] data_p0;
    logic             par_p0;

    always_comb begin
        src_p0  = sel[0] ? SRC_B : SRC_A;
        data_p0 = (src_p0 == SRC_B) ? data_b : data_a;
        par_p0  = word_parity(data_p0);
    end

    // ---- Stage p1: optional output register ----
    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] data_p1;
            sel_src_e         src_p1;
            logic             par_p1;

            // Parity is registered alongside the word so all outputs move
            // on the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_p1 <= '0;
                    src_p1  <= SRC_A;
                    par_p1  <= 1'b0;
                end else begin
                    data_p1 <= data_p0;
                    src_p1  <= src_p0;
                    par_p1  <= par_p0;
                end
            end

            assign data_out   = data_p1;
            assign sel_odd    = (src_p1 == SRC_B);
            assign out_parity = par_p1;
        end else begin : g_comb_out
            logic unused_ctl;
            assign unused_ctl = clk ^ rst_n;

            assign data_out   = data_p0;
            assign sel_odd    = (src_p0 == SRC_B);
            assign out_parity = par_p0;
        end
    endgenerate

endmodule : param_paritysel_mux

// File: tb/tb_param_paritysel_mux.sv
// -----------------------------------------------------------------------------
// tb_param_paritysel_mux
// Scoreboard bench: stimulus pushes expected responses computed by a
// behavioural model, a monitor pops and compares once per cycle. A second,
// combinational instance is exercised with its clock idle and reset held.
// -----------------------------------------------------------------------------
module tb_param_paritysel_mux;
    import paritysel_pkg::*;

    localparam int W  = 8;
    localparam int SW = 5;

    typedef struct {
        logic [W-1:0] data;
        sel_src_e     src;
        logic         par;
        string        tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [W-1:0]  data_a = '0;
    logic [W-1:0]  data_b = '0;
    logic [W-1:0]  data_out;
    logic          sel_odd;
    logic          out_parity;

    logic          clk_idle = 1'b0;
    logic          rst_idle = 1'b0;
    logic [SW-1:0] sel_c = '0;
    logic [W-1:0]  a_c = '0;
    logic [W-1:0]  b_c = '0;
    logic [W-1:0]  dout_c;
    logic          odd_c;
    logic          par_c;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    param_paritysel_mux #(.WIDTH(W), .SEL_W(SW), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .data_a(data_a), .data_b(data_b),
        .data_out(data_out), .sel_odd(sel_odd), .out_parity(out_parity)
    );

    param_paritysel_mux #(.WIDTH(W), .SEL_W(SW), .REG_OUT(0)) dut_comb (
        .clk(clk_idle), .rst_n(rst_idle), .sel(sel_c), .data_a(a_c), .data_b(b_c),
        .data_out(dout_c), .sel_odd(odd_c), .out_parity(par_c)
    );

    always #5 clk = ~clk;

    // Reference model: even code -> A, odd code -> B; parity = popcount mod 2.
    function automatic exp_t model(input int code, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input string tag);
        exp_t e;
        if (code % 2 == 0) begin
            e.data = a;
            e.src  = SRC_A;
        end else begin
            e.data = b;
            e.src  = SRC_B;
        end
        e.par = logic'($countones(e.data) % 2);
        e.tag = tag;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, ".data"}, 32'(data_out), 32'h0);
        check({name, ".odd"},  32'(sel_odd), 32'h0);
        check({name, ".par"},  32'(out_parity), 32'h0);
    endtask

    // Inputs change on the falling edge; the next rising edge captures them.
    task automatic drive(input logic [SW-1:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input string tag);
        @(negedge clk);
        sel    = s;
        data_a = a;
        data_b = b;
        exp_q.push_back(model(int'(s), a, b, tag));
    endtask

    // Monitor: every cycle is a transfer, so one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".data"}, 32'(data_out), 32'(e.data));
                check({e.tag, ".odd"},  32'(sel_odd), 32'(e.src == SRC_B));
                check({e.tag, ".par"},  32'(out_parity), 32'(e.par));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with live inputs: outputs stay zero.
        sel = 5'd3; data_a = 8'h55; data_b = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end

        // Release reset; first edge captures current inputs.
        @(negedge clk);
        sel = 5'd2; data_a = 8'h55; data_b = 8'hAA;
        rst_n = 1'b1;
        exp_q.push_back(model(2, 8'h55, 8'hAA, "even_sel"));
        drive(5'd3, 8'h55, 8'hAA, "odd_sel");
        drive(5'd3, 8'h55, 8'h01, "odd_par");

        // Upper select bits ignored.
        for (int s = 0; s < 32; s++)
            drive(SW'(s), 8'h0F, 8'hF0, "sweep");

        // Toggling select, then async reset between edges.
        for (int i = 0; i < 6; i++)
            drive(SW'(i), 8'h3C, 8'hC3, "toggle");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sel = 5'd1; data_a = 8'hFF; data_b = 8'h7E;
            @(posedge clk);
            #1;
            check_zero("rst_hold_mid");
        end
        @(negedge clk);
        sel = 5'd7; data_a = 8'h12; data_b = 8'hB7;
        rst_n = 1'b1;
        exp_q.push_back(model(7, 8'h12, 8'hB7, "post_rst"));

        // Randomized traffic.
        for (int i = 0; i < 150; i++)
            drive(SW'($urandom), W'($urandom), W'($urandom), "random");

        @(posedge clk);
        #2;
        check("queue_drain", 32'(exp_q.size()), 32'h0);

        // Combinational build, clock idle and reset asserted.
        sel_c = 5'd2; a_c = 8'h55; b_c = 8'hAA;
        #1;
        check("comb_even.data", 32'(dout_c), 32'h55);
        check("comb_even.odd",  32'(odd_c), 32'h0);
        check("comb_even.par",  32'(par_c), 32'h0);
        sel_c = 5'd3;
        #1;
        check("comb_odd.data", 32'(dout_c), 32'hAA);
        check("comb_odd.odd",  32'(odd_c), 32'h1);
        check("comb_odd.par",  32'(par_c), 32'h0);
        for (int i = 0; i < 40; i++) begin
            exp_t e;
            sel_c = SW'($urandom); a_c = W'($urandom); b_c = W'($urandom);
            e = model(int'(sel_c), a_c, b_c, "comb_rand");
            #1;
            check("comb_rand.data", 32'(dout_c), 32'(e.data));
            check("comb_rand.odd",  32'(odd_c), 32'(e.src == SRC_B));
            check("comb_rand.par",  32'(par_c), 32'(e.par));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_param_paritysel_mux
